// File: rtl/rf_pkg.sv
// Shared widths and types for the operand register file and its ALU neighbours.
package rf_pkg;

    localparam int RF_N     = 8;
    localparam int RF_M     = 3;
    localparam int RF_DEPTH = 2 ** RF_M;

    typedef logic [RF_N-1:0] rf_data_t;
    typedef logic [RF_M-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file.
// Build option: define RF_BYPASS_EN to forward a same-edge write to this port.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int N = RF_N,
    parameter int M = RF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read_en,
    input  logic [M-1:0] read_addr,
    input  logic [N-1:0] mem [2**M],
    input  logic         write_en,
    input  logic [M-1:0] write_addr,
    input  logic [N-1:0] write_data,
    output logic [N-1:0] q
);

    logic [N-1:0] read_value;
    logic [N-1:0] q_reg;

`ifdef RF_BYPASS_EN
    // Forward the incoming write when it targets the address being read this edge.
    always_comb begin
        read_value = mem[read_addr];
        if (write_en && (write_addr == read_addr)) begin
            read_value = write_data;
        end
    end
`else
    // Without forwarding the write-side inputs are intentionally ignored.
    logic unused_write_side;
    assign unused_write_side = &{1'b0, write_en, write_addr, write_data};

    // Plain array read; a same-edge write is seen on the following read.
    always_comb begin
        read_value = mem[read_addr];
    end
`endif

    // Output register: loads on strobe, otherwise holds the last operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (read_en) begin
            q_reg <= read_value;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_file.sv
// Dual-read, single-write operand register file feeding the ALU A/B inputs.
// Build option: RF_BYPASS_EN enables write-to-read forwarding on both ports.
module register_file
    import rf_pkg::*;
#(
    parameter int N = RF_N,
    parameter int M = RF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         write_en,
    input  logic [M-1:0] write_addr,
    input  logic [N-1:0] write_data,
    input  logic         readA_en,
    input  logic [M-1:0] readA_addr,
    input  logic         readB_en,
    input  logic [M-1:0] readB_addr,
    output logic [N-1:0] QA,
    output logic [N-1:0] QB
);

    localparam int DEPTH = 2 ** M;

    // Flop-based storage: every word must clear on asynchronous reset.
    logic [N-1:0] mem_reg [DEPTH];

    // Write port; reset wins over a pending write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_en) begin
            mem_reg[write_addr] <= write_data;
        end
    end

    logic         port_en   [2];
    logic [M-1:0] port_addr [2];
    logic [N-1:0] port_q    [2];

    assign port_en[0]   = readA_en;
    assign port_addr[0] = readA_addr;
    assign port_en[1]   = readB_en;
    assign port_addr[1] = readB_addr;

    // Two identical read ports: index 0 is operand A, index 1 is operand B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            rf_read_port #(
                .N (N),
                .M (M)
            ) u_port (
                .clk        (clk),
                .rst        (rst),
                .read_en    (port_en[gi]),
                .read_addr  (port_addr[gi]),
                .mem        (mem_reg),
                .write_en   (write_en),
                .write_addr (write_addr),
                .write_data (write_data),
                .q          (port_q[gi])
            );
        end
    endgenerate

    assign QA = port_q[0];
    assign QB = port_q[1];

endmodule
